// File: rtl/shadow_tracer_pkg.sv
// shadow_tracer_pkg: shared record layout, frame constants and scheduler states for the shadow tracer
package shadow_tracer_pkg;
  localparam logic [7:0] REC_SYNC = 8'hA5;
  localparam int REC_BYTES = 7;
  typedef struct packed {
    logic [15:0] cyc;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  ctrl;
  } trace_rec_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} sched_state_t;
  // Byte i of the outgoing frame, sync byte first, then the record MSB first.
  function automatic logic [7:0] rec_byte(input trace_rec_t r, input logic [2:0] i);
    logic [55:0] f;
    f = {REC_SYNC, r} << {i, 3'b000};
    return f[55:48];
  endfunction
endpackage

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serializer, one byte per start pulse accepted while ready
//   CLK_n   in   clock, rising edge
//   RESET_n in   asynchronous active-low reset
//   start   in   byte request, accepted on an edge where ready=1
//   data    in   byte to send, captured on the accepting edge
//   ready   out  high when idle; low from the accepting edge until the stop bit ends
//   TXD     out  serial line, idle high
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 35
) (
  input  logic       CLK_n,
  input  logic       RESET_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       TXD
);
  logic       active;
  logic [7:0] baud;
  logic [7:0] sh;
  logic [3:0] bit_i;
  assign ready = ~active;
  // bit_i 0 = start, 1..8 = data, 9 = stop; bit_i[3] marks the stop bit and beyond.
  always_ff @(posedge CLK_n or negedge RESET_n)
    if (!RESET_n) begin
      active <= 1'b0;
      baud   <= 8'd0;
      bit_i  <= 4'd0;
      sh     <= 8'd0;
      TXD    <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        baud   <= 8'd0;
        bit_i  <= 4'd0;
        sh     <= data;
        TXD    <= 1'b0;
      end
    end else if (baud == 8'(CLKS_PER_BIT - 1)) begin
      baud   <= 8'd0;
      bit_i  <= bit_i + 4'd1;
      active <= bit_i != 4'd9;
      TXD    <= bit_i[3] | sh[bit_i[2:0]];
    end else
      baud <= baud + 8'd1;
endmodule

// File: rtl/shadow_mismatch_reporter.sv
// shadow_mismatch_reporter: snapshots the Z80 bus on each new tracer mismatch and streams 7-byte records over UART
//   CLK_n      in   target Z80 clock, rising edge
//   RESET_n    in   asynchronous active-low reset
//   arm        in   enables capture and cycle counting
//   match      in   tracer match flag; a 1->0 transition while armed captures a record
//   A, D, ctrl in   bus values sampled into the record
//   TXD        out  UART 8N1 line, idle high
//   busy       out  FIFO non-empty or frame in flight
//   overflow   out  sticky, a record was dropped on a full FIFO
//   rec_count  out  captured records, saturating at 255
module shadow_mismatch_reporter import shadow_tracer_pkg::*; #(
  parameter int CLKS_PER_BIT = 35,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        CLK_n,
  input  logic        RESET_n,
  input  logic        arm,
  input  logic        match,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic [7:0]  ctrl,
  output logic        TXD,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  rec_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [15:0]  cyc;
  logic         match_prev, ev, push, pop, full, empty, ready, tx_start;
  logic [AW:0]  wp, rp;
  logic [2:0]   idx, idx_nx;
  logic [7:0]   tx_data;
  trace_rec_t   mem [FIFO_DEPTH];
  sched_state_t state, state_nx;
  assign ev      = arm & match_prev & ~match;
  assign empty   = wp == rp;
  assign full    = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  // The head record stays in the FIFO until its last stop bit, so a pop on the
  // same edge frees the slot a push into a full FIFO needs.
  assign pop     = (state == ST_WAIT) && ready && (idx == 3'(REC_BYTES - 1));
  assign push    = ev & (~full | pop);
  assign busy    = ~empty | (state != ST_IDLE);
  assign tx_data = rec_byte(mem[rp[AW-1:0]], idx);
  always_ff @(posedge CLK_n or negedge RESET_n)
    if (!RESET_n) begin
      cyc        <= 16'd0;
      match_prev <= 1'b1;
      wp         <= '0;
      rp         <= '0;
      overflow   <= 1'b0;
      rec_count  <= 8'd0;
      state      <= ST_IDLE;
      idx        <= 3'd0;
    end else begin
      cyc        <= arm ? cyc + 16'd1 : 16'd0;
      match_prev <= match;
      wp         <= wp + {{AW{1'b0}}, push};
      rp         <= rp + {{AW{1'b0}}, pop};
      overflow   <= overflow | (ev & full & ~pop);
      rec_count  <= rec_count + {7'd0, ev && rec_count != 8'hFF};
      state      <= state_nx;
      idx        <= idx_nx;
    end
  always_ff @(posedge CLK_n)
    if (push) mem[wp[AW-1:0]] <= {cyc, A, D, ctrl};
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tx_start = 1'b0;
    case (state)
      ST_IDLE: if (!empty) begin
        state_nx = ST_SEND;
        idx_nx   = 3'd0;
      end
      ST_SEND: if (ready) begin
        tx_start = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: if (ready) begin
        state_nx = pop ? ST_IDLE : ST_SEND;
        idx_nx   = idx + 3'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLK_n  (CLK_n),
    .RESET_n(RESET_n),
    .start  (tx_start),
    .data   (tx_data),
    .ready  (ready),
    .TXD    (TXD)
  );
endmodule

// File: tb/tb_shadow_mismatch_reporter.sv
// tb_shadow_mismatch_reporter: randomized bench with a record-queue reference model and a UART frame decoder
module tb_shadow_mismatch_reporter;
  localparam int C = 4, DEPTH = 4, P = 10 * C + 2;
  logic        CLK_n = 0, RESET_n = 0, arm = 0, match = 1;
  logic [15:0] A = 0;
  logic [7:0]  D = 0, ctrl = 0;
  logic        TXD, busy, overflow;
  logic [7:0]  rec_count;
  int n_chk = 0, n_pass = 0;

  shadow_mismatch_reporter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .CLK_n(CLK_n), .RESET_n(RESET_n), .arm(arm), .match(match), .A(A), .D(D), .ctrl(ctrl),
    .TXD(TXD), .busy(busy), .overflow(overflow), .rec_count(rec_count)
  );

  always #5 CLK_n = ~CLK_n;

  int          ncyc = 0;
  bit          mprev = 1, m_ev = 0, m_ovf = 0, sending = 0;
  logic [15:0] mcyc = 0;
  int          m_cnt = 0, pop_at = 0;
  logic [55:0] mq[$];
  logic [55:0] m_r;
  logic [7:0]  exp_q[$];
  int          exp_st[$];

  always @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      mq.delete();
      sending = 0;
      mcyc = 0;
      mprev = 1;
      m_cnt = 0;
      m_ovf = 0;
    end else begin
      ncyc++;
      m_ev = arm && mprev && !match;
      mprev = match;
      if (sending && ncyc == pop_at) begin
        void'(mq.pop_front());
        sending = 0;
      end
      if (m_ev) begin
        if (m_cnt < 255) m_cnt++;
        if (mq.size() < DEPTH) mq.push_back({8'hA5, mcyc, A, D, ctrl});
        else m_ovf = 1;
      end
      mcyc = arm ? mcyc + 16'd1 : 16'd0;
      if (!sending && mq.size() > 0) begin
        sending = 1;
        pop_at = ncyc + 1 + 7 * P;
        for (int i = 0; i < 7; i++) begin
          m_r = mq[0] << (8 * i);
          exp_q.push_back(m_r[55:48]);
          exp_st.push_back(ncyc + 2 + i * P);
        end
      end
    end
  end

  logic [7:0] rx_q[$];
  int         rx_st[$];
  logic       rx_stop[$];
  bit         mon_act = 0;
  int         mon_t = 0, mon_st = 0;
  logic [7:0] mon_sh = 0;

  always @(negedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) mon_act = 0;
    else if (!mon_act) begin
      if (TXD === 1'b0) begin
        mon_act = 1;
        mon_t = 0;
        mon_st = ncyc;
      end
    end else begin
      mon_t++;
      if (mon_t > C && mon_t < 9 * C && mon_t % C == C / 2) mon_sh[3'(mon_t / C - 1)] = TXD;
      if (mon_t == 9 * C + C / 2) begin
        rx_q.push_back(mon_sh);
        rx_st.push_back(mon_st);
        rx_stop.push_back(TXD);
        mon_act = 0;
      end
    end
  end

  int cr = 0, ce = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] rxb(input int i);
    return i < rx_q.size() ? rx_q[i] : 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK_n);
      A = 16'($urandom);
      D = 8'($urandom);
      ctrl = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_n);
    #1 RESET_n = 0;
    arm = 0;
    match = 1;
    tick(3);
    RESET_n = 1;
    tick(1);
  endtask

  task automatic ev_pulse();
    match = 0;
    tick(1);
    match = 1;
    tick(1);
  endtask

  task automatic drain();
    int t = 0;
    while (busy !== 1'b0 && t < 5000) begin
      tick(1);
      t++;
    end
    chk("drain_idle", busy, 0);
    tick(4);
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_q.size() < n && t < 3000) begin
      tick(1);
      t++;
    end
    chk("wait_rx", rx_q.size() >= n, 1);
  endtask

  task automatic cmp_stream(input bit aborted);
    int n = rx_q.size() - cr;
    if (!aborted) chk("byte_count", n, exp_q.size() - ce);
    for (int i = 0; i < n && ce + i < exp_q.size(); i++) begin
      chk($sformatf("byte%0d", cr + i), rx_q[cr + i], exp_q[ce + i]);
      chk($sformatf("start%0d", cr + i), rx_st[cr + i], exp_st[ce + i]);
      chk($sformatf("stop%0d", cr + i), rx_stop[cr + i], 1);
    end
    cr = rx_q.size();
    ce = exp_q.size();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, ev_edge, r;
    do_reset();
    chk("rst_txd", TXD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", rec_count, 0);

    arm = 1;
    tick(10);
    A = 16'h1234; D = 8'h5A; ctrl = 8'hB7; match = 0;
    b = rx_q.size();
    ev_edge = ncyc + 1;
    @(negedge CLK_n);
    match = 1;
    chk("push_busy", busy, 1);
    drain();
    cmp_stream(0);
    chk("single_sync", rxb(b), 8'hA5);
    chk("single_cyc", {rxb(b + 1), rxb(b + 2)}, 16'h000A);
    chk("single_addr", {rxb(b + 3), rxb(b + 4)}, 16'h1234);
    chk("single_data", rxb(b + 5), 8'h5A);
    chk("single_ctrl", rxb(b + 6), 8'hB7);
    chk("single_lat", b < rx_st.size() ? rx_st[b] : -1, ev_edge + 2);
    chk("single_cnt", rec_count, 1);

    do_reset();
    arm = 1;
    tick(5);
    b = rx_q.size();
    match = 0; tick(50);
    match = 1; tick(5);
    match = 0; tick(5);
    match = 1;
    drain();
    cmp_stream(0);
    chk("sust_bytes", rx_q.size() - b, 14);
    chk("sust_cnt", rec_count, 2);

    do_reset();
    arm = 1;
    tick(3);
    repeat (6) ev_pulse();
    drain();
    cmp_stream(0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_model", overflow, m_ovf);
    chk("ovf_cnt", rec_count, 6);

    do_reset();
    arm = 1;
    tick(65539);
    b = rx_q.size();
    match = 0;
    tick(1);
    match = 1;
    drain();
    cmp_stream(0);
    chk("wrap_cyc", {rxb(b + 1), rxb(b + 2)}, 16'h0003);

    do_reset();
    arm = 1;
    tick(7);
    b = rx_q.size();
    repeat (3) ev_pulse();
    wait_rx(b + 2);
    tick(5);
    arm = 0;
    repeat (5) ev_pulse();
    drain();
    cmp_stream(0);
    chk("armdrop_bytes", rx_q.size() - b, 21);
    chk("armdrop_cnt", rec_count, 3);

    do_reset();
    arm = 1;
    tick(3);
    b = rx_q.size();
    repeat (6) ev_pulse();
    wait_rx(b + 4);
    tick(10);
    chk("pre_rst_ovf", overflow, 1);
    #1 RESET_n = 0;
    #1;
    chk("mid_rst_txd", TXD, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_cnt", rec_count, 0);
    cmp_stream(1);
    tick(3);
    RESET_n = 1;
    r = rx_q.size();
    tick(600);
    chk("no_residual", rx_q.size(), r);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_txd", TXD, 1);
    cr = rx_q.size();
    ce = exp_q.size();

    do_reset();
    arm = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) arm = ~arm;
      match = $urandom_range(0, 7) != 0;
      tick(1);
    end
    match = 1;
    drain();
    cmp_stream(0);
    chk("rand_cnt", rec_count, m_cnt);
    chk("rand_ovf", overflow, m_ovf);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
